// File: rtl/bram_word_port.sv
// bram_word_port
//
// Word-access front end for an 8-bit wide, 2^ADDR_W deep block RAM port.
// A 32-bit load/store request accepted on the req_* handshake is split into
// four byte beats on the RAM port. Load bytes are collected one cycle after
// each RAM edge, to account for the RAM's read latency. A 32-bit response is
// then returned on the rsp_* handshake. One request is in flight at a time.
//
// Ports
//   clk        sole clock (the RAM port shares it)
//   rst_n      asynchronous active-low reset
//   req_valid  request present            req_ready  block can accept
//   req_we     1 = store, 0 = load        req_addr   byte address, [1:0] ignored
//   req_wdata  store data, little-endian  req_wstrb  store byte enables
//   rsp_valid  response present           rsp_ready  consumer accepts
//   rsp_rdata  load data (0 for stores)
//   mem_en / mem_we / mem_addr / mem_din  RAM port A controls
//   mem_dout   RAM read data, valid the cycle after an enabled read edge
//
// All outputs come straight from flops. Each output's value for the next
// cycle is computed in the combinational block.
module bram_word_port #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT  = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state_reg, state_next;
  logic [1:0] beat_reg, beat_next;

  // Request fields latched at acceptance.
  logic              we_reg;
  logic [ADDR_W-3:0] word_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        wstrb_reg;

  // Output registers and their next values.
  logic              req_ready_reg, req_ready_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic              mem_en_reg, mem_en_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [7:0]        mem_din_reg, mem_din_next;
  logic [31:0]       rdata_reg;

  logic accept;
  assign accept = req_valid && req_ready_reg;

  // Beat source selection. The first beat is issued on the acceptance edge,
  // before the latched copies exist, so it takes the fields from the inputs.
  logic              issue;
  logic [1:0]        issue_idx;
  logic              src_we;
  logic [ADDR_W-3:0] src_word;
  logic [31:0]       src_wdata;
  logic [3:0]        src_wstrb;
  logic [7:0]        src_byte;

  always_comb begin
    state_next     = state_reg;
    beat_next      = beat_reg;
    req_ready_next = req_ready_reg;
    rsp_valid_next = rsp_valid_reg;
    issue          = 1'b0;
    issue_idx      = 2'd0;

    case (state_reg)
      S_IDLE: begin
        req_ready_next = 1'b1;
        if (accept) begin
          state_next     = S_BEAT;
          beat_next      = 2'd0;
          req_ready_next = 1'b0;
          issue          = 1'b1;
          issue_idx      = 2'd0;
        end
      end
      S_BEAT: begin
        if (beat_reg == 2'd3) begin
          state_next = S_DRAIN;
        end else begin
          beat_next = beat_reg + 2'd1;
          issue     = 1'b1;
          issue_idx = beat_reg + 2'd1;
        end
      end
      S_DRAIN: begin
        state_next     = S_RESP;
        rsp_valid_next = 1'b1;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_next     = S_IDLE;
          rsp_valid_next = 1'b0;
          req_ready_next = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    if (state_reg == S_IDLE) begin
      src_we    = req_we;
      src_word  = req_addr[ADDR_W-1:2];
      src_wdata = req_wdata;
      src_wstrb = req_wstrb;
    end else begin
      src_we    = we_reg;
      src_word  = word_reg;
      src_wdata = wdata_reg;
      src_wstrb = wstrb_reg;
    end

    case (issue_idx)
      2'd0:    src_byte = src_wdata[7:0];
      2'd1:    src_byte = src_wdata[15:8];
      2'd2:    src_byte = src_wdata[23:16];
      default: src_byte = src_wdata[31:24];
    endcase

    // RAM controls default to idle while holding address/data, so the port
    // only toggles the lines that matter.
    mem_en_next   = 1'b0;
    mem_we_next   = 1'b0;
    mem_addr_next = mem_addr_reg;
    mem_din_next  = mem_din_reg;
    if (issue) begin
      // Low two bits come from the beat index, never from the request, so
      // the word stays inside its aligned 4-byte block (no wrap at the top).
      mem_addr_next = {src_word, issue_idx};
      if (src_we) begin
        mem_en_next  = src_wstrb[issue_idx];
        mem_we_next  = src_wstrb[issue_idx];
        mem_din_next = src_byte;
      end else begin
        mem_en_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      beat_reg      <= 2'd0;
      we_reg        <= 1'b0;
      word_reg      <= '0;
      wdata_reg     <= 32'd0;
      wstrb_reg     <= 4'd0;
      req_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_din_reg   <= 8'd0;
    end else begin
      state_reg     <= state_next;
      beat_reg      <= beat_next;
      req_ready_reg <= req_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_din_reg   <= mem_din_next;
      if (accept) begin
        we_reg    <= req_we;
        word_reg  <= req_addr[ADDR_W-1:2];
        wdata_reg <= req_wdata;
        wstrb_reg <= req_wstrb;
      end
    end
  end

  // Load capture: byte i arrives on mem_dout one cycle after its RAM edge,
  // i.e. during beat i+1 (i<3) or during DRAIN (i=3).
  logic       cap_en;
  logic [1:0] cap_idx;
  assign cap_en  = !we_reg && (((state_reg == S_BEAT) && (beat_reg != 2'd0)) ||
                               (state_reg == S_DRAIN));
  assign cap_idx = (state_reg == S_DRAIN) ? 2'd3 : (beat_reg - 2'd1);

  // Lanes are cleared on acceptance so a store responds with zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_reg[8*gi +: 8] <= 8'd0;
      end else if (accept) begin
        rdata_reg[8*gi +: 8] <= 8'd0;
      end else if (cap_en && (cap_idx == 2'(gi))) begin
        rdata_reg[8*gi +: 8] <= mem_dout;
      end
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rdata_reg;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_din   = mem_din_reg;

endmodule

// File: tb/tb_bram_word_port.sv
// Testbench for bram_word_port: table of load/store transactions against a
// behavioural byte RAM, plus hand-written sequences for response
// back-pressure, back-to-back requests and reset during a store.
module tb_bram_word_port;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;

  int n_checks = 0;
  int n_fail   = 0;

  bram_word_port #(.ADDR_W(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: one-cycle registered read, read-before-write.
  logic [7:0] ram [4096];
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    mem_dout = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      mem_dout <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_din;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Present a request and return just after its acceptance edge. The inputs
  // are then scrambled to show that the block uses its latched copy.
  task automatic start_req(input logic we, input logic [11:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
    int n;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = addr ^ 12'hA50;
    req_wdata = ~wdata;
    req_wstrb = ~wstrb;
  endtask

  // Full transaction: returns response data, cycles from acceptance to the
  // first rsp_valid cycle, and which beat cycles (1..4) carried a RAM write.
  task automatic do_txn(input logic we, input logic [11:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        output logic [31:0] rdata, output int lat,
                        output logic [3:0] wmask);
    start_req(we, addr, wdata, wstrb);
    lat   = 0;
    wmask = 4'b0000;
    do begin
      @(negedge clk);
      lat++;
      if (mem_en && mem_we) begin
        if (lat >= 1 && lat <= 4) wmask[lat-1] = 1'b1;
        else wmask = 4'bxxxx;
      end
    end while (!rsp_valid && lat < 30);
    rdata     = rsp_rdata;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("ready_after_rsp", {31'd0, req_ready}, 32'd1);
    check("valid_after_rsp", {31'd0, rsp_valid}, 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_wmask;
  } vec_t;

  vec_t vecs [10];

  logic [31:0] rd;
  int          lat;
  logic [3:0]  wm;
  int          acc [2];
  int          nacc;
  logic [11:0] maddr [4];
  int          naddr;
  logic [31:0] rsps [2];
  int          nrsp;

  initial begin
    vecs[0] = '{1'b1, 12'h010, 32'hDEADBEEF, 4'b1111, 32'h00000000, 4'b1111};
    vecs[1] = '{1'b0, 12'h010, 32'h0,        4'b0000, 32'hDEADBEEF, 4'b0000};
    vecs[2] = '{1'b1, 12'h010, 32'h11223344, 4'b0101, 32'h00000000, 4'b0101};
    vecs[3] = '{1'b0, 12'h010, 32'h0,        4'b1111, 32'hDE22BE44, 4'b0000};
    vecs[4] = '{1'b1, 12'hFFC, 32'hCAFEF00D, 4'b1111, 32'h00000000, 4'b1111};
    vecs[5] = '{1'b0, 12'hFFF, 32'h0,        4'b0000, 32'hCAFEF00D, 4'b0000};
    vecs[6] = '{1'b0, 12'h000, 32'h0,        4'b0000, 32'h00000000, 4'b0000};
    vecs[7] = '{1'b1, 12'h010, 32'hFFFFFFFF, 4'b0000, 32'h00000000, 4'b0000};
    vecs[8] = '{1'b0, 12'h012, 32'h0,        4'b0000, 32'hDE22BE44, 4'b0000};
    vecs[9] = '{1'b1, 12'h020, 32'h12345678, 4'b1111, 32'h00000000, 4'b1111};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 12'h000;
    req_wdata = 32'h0;
    req_wstrb = 4'h0;
    rsp_ready = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_mem_en",    {31'd0, mem_en}, 32'd0);
    check("rst_mem_we",    {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr",  {20'd0, mem_addr}, 32'd0);
    check("rst_mem_din",   {24'd0, mem_din}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Table-driven transactions.
    for (int i = 0; i < 10; i++) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, lat, wm);
      $display("txn %0d: we=%0b addr=0x%03h wdata=0x%08h wstrb=%04b -> rdata=0x%08h lat=%0d wmask=%04b",
               i, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, lat, wm);
      check($sformatf("rdata[%0d]", i), rd, vecs[i].exp_rdata);
      check($sformatf("latency[%0d]", i), lat, 32'd6);
      check($sformatf("wmask[%0d]", i), {28'd0, wm}, {28'd0, vecs[i].exp_wmask});
    end
    check("ram_000_untouched", {24'd0, ram[12'h000]}, 32'd0);
    check("ram_ffc", {24'd0, ram[12'hFFC]}, 32'h0D);

    // Response back-pressure on a load of 0x020.
    start_req(1'b0, 12'h020, 32'h0, 4'h0);
    lat = 0;
    while (!rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", lat, 32'd6);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_valid[%0d]", c), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("bp_rdata[%0d]", c), rsp_rdata, 32'h12345678);
      check($sformatf("bp_ready[%0d]", c), {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_ready_after", {31'd0, req_ready}, 32'd1);
    check("bp_valid_after", {31'd0, rsp_valid}, 32'd0);
    $display("backpressure: load 0x020 held 5 cycles, rdata=0x%08h", rsp_rdata);

    // Back-to-back loads with req_valid held high and rsp_ready tied 1.
    nacc = 0; naddr = 0; nrsp = 0;
    req_we    = 1'b0;
    req_addr  = 12'h013;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (nacc == 1 && req_addr == 12'h013) req_addr = 12'h020;
      if (nacc == 2) req_valid = 1'b0;
      if (req_valid && req_ready && nacc < 2) begin
        acc[nacc] = c;
        nacc++;
      end
      if (mem_en && naddr < 4) begin
        maddr[naddr] = mem_addr;
        naddr++;
      end
      if (rsp_valid && nrsp < 2) begin
        rsps[nrsp] = rsp_rdata;
        nrsp++;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("b2b_accepts", nacc, 32'd2);
    check("b2b_spacing", (nacc == 2) ? (acc[1] - acc[0]) : -1, 32'd7);
    check("b2b_responses", nrsp, 32'd2);
    for (int k = 0; k < 4; k++)
      check($sformatf("b2b_mem_addr[%0d]", k), (naddr > k) ? {20'd0, maddr[k]} : 32'hFFFFFFFF,
            32'h010 + k);
    check("b2b_rdata0", (nrsp > 0) ? rsps[0] : 32'hFFFFFFFF, 32'hDE22BE44);
    check("b2b_rdata1", (nrsp > 1) ? rsps[1] : 32'hFFFFFFFF, 32'h12345678);
    $display("back-to-back: accepts=%0d spacing=%0d responses=%0d", nacc,
             (nacc == 2) ? acc[1] - acc[0] : -1, nrsp);

    // Reset during cycle 3 of a store to 0x040.
    @(negedge clk);
    start_req(1'b1, 12'h040, 32'hAABBCCDD, 4'b1111);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_mem_en",    {31'd0, mem_en}, 32'd0);
    check("mid_rst_mem_we",    {31'd0, mem_we}, 32'd0);
    check("mid_rst_mem_addr",  {20'd0, mem_addr}, 32'd0);
    check("mid_rst_mem_din",   {24'd0, mem_din}, 32'd0);
    check("mid_rst_rdata",     rsp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    check("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_txn(1'b0, 12'h040, 32'h0, 4'h0, rd, lat, wm);
    $display("reset-abort: load 0x040 after aborted store -> rdata=0x%08h", rd);
    check("abort_rdata", rd, 32'h0000CCDD);
    check("abort_latency", lat, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
